// File: rtl/chan_reg_bank.sv
// Multi-channel register bank: one write port demuxed into NUM_CH words, two independent registered read ports.
// Latency: write lands in storage after 1 edge; read data/valid appear 1 cycle after the sampling edge.
// Backpressure: none; a write and one read per port are accepted every cycle with no stalls.
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   clr                   : bulk clear of all channels
//   wr_en/wr_sel/wr_data  : write strobe, channel index, data
//   rd_en_x/rd_sel_x      : read strobe and channel index for port x (a, b)
//   rd_data_x/rd_vld_x    : registered read data and one-cycle valid for port x
//   sel_err               : one-cycle pulse, an enabled port used an out-of-range index
module chan_reg_bank #(
  parameter int NUM_CH   = 32,
  parameter int WIDTH    = 20,
  parameter int SEL_W    = $clog2(NUM_CH),
  parameter bit ZERO_CH0 = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en_a,
  input  logic [SEL_W-1:0] rd_sel_a,
  input  logic             rd_en_b,
  input  logic [SEL_W-1:0] rd_sel_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic             rd_vld_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_vld_b,
  output logic             sel_err
);

  // One extra bit so the compare also works when NUM_CH == 2**SEL_W.
  localparam logic [SEL_W:0] LIMIT = (SEL_W+1)'(NUM_CH);

  logic [WIDTH-1:0] mem_q [NUM_CH];
  logic [WIDTH-1:0] mem_d [NUM_CH];
  // Value each channel presents to a same-cycle read: clear and write bypass
  // already applied. It is also exactly the next storage contents.
  logic [WIDTH-1:0] vis   [NUM_CH];

  logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
  logic             rd_vld_a_q, rd_vld_a_d;
  logic             rd_vld_b_q, rd_vld_b_d;
  logic             sel_err_q, sel_err_d;

  logic in_w, in_a, in_b, wr_ok;

  always_comb begin
    in_w  = {1'b0, wr_sel}   < LIMIT;
    in_a  = {1'b0, rd_sel_a} < LIMIT;
    in_b  = {1'b0, rd_sel_b} < LIMIT;
    wr_ok = wr_en && in_w && !(ZERO_CH0 && (wr_sel == '0));

    for (int i = 0; i < NUM_CH; i++) begin
      if ((ZERO_CH0 && (i == 0)) || clr) begin
        vis[i] = '0;
      end else if (wr_ok && (wr_sel == SEL_W'(i))) begin
        vis[i] = wr_data;
      end else begin
        vis[i] = mem_q[i];
      end
      mem_d[i] = vis[i];
    end

    rd_data_a_d = rd_data_a_q;
    if (rd_en_a) begin
      rd_data_a_d = in_a ? vis[rd_sel_a] : '0;
    end
    rd_data_b_d = rd_data_b_q;
    if (rd_en_b) begin
      rd_data_b_d = in_b ? vis[rd_sel_b] : '0;
    end
    rd_vld_a_d = rd_en_a;
    rd_vld_b_d = rd_en_b;

    sel_err_d = (wr_en && !in_w) || (rd_en_a && !in_a) || (rd_en_b && !in_b);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_vld_a_q  <= 1'b0;
      rd_vld_b_q  <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      rd_vld_a_q  <= rd_vld_a_d;
      rd_vld_b_q  <= rd_vld_b_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign rd_vld_a  = rd_vld_a_q;
  assign rd_vld_b  = rd_vld_b_q;
  assign sel_err   = sel_err_q;

endmodule

// File: doc/chan_reg_bank.md
# chan_reg_bank

Parametrised multi-channel register bank. It has one write port, a select-driven demultiplexer into NUM_CH storage words, and two independent registered read ports, each a select-driven multiplexer. It replaces the fixed 32 x 20-bit combinational channel mux/demux pair in the datapath. It adds storage, read enables, write-to-read bypass, an optional hardwired-zero channel, bulk clear, and out-of-range select detection.

## Interface
- NUM_CH, default 32: number of channels (2..64; need not be a power of two).
- WIDTH, default 20: data bits per channel.
- SEL_W, default $clog2(NUM_CH): selector width.
- ZERO_CH0, default 0: 1 = channel 0 always reads 0 and ignores writes.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- clr  in  1  synchronous bulk clear of all channels.
- wr_en  in  1  write strobe.
- wr_sel  in  SEL_W  write channel index.
- wr_data  in  WIDTH  write data.
- rd_en_a / rd_en_b  in  1  read strobe, port A / port B.
- rd_sel_a / rd_sel_b  in  SEL_W  read channel index, per port.
- rd_data_a / rd_data_b  out  WIDTH  registered read data.
- rd_vld_a / rd_vld_b  out  1  high one cycle after an accepted read.
- sel_err  out  1  one-cycle pulse flagging an out-of-range select on any enabled port.

## Operation
- Storage: NUM_CH x WIDTH flops. On reset, all channels are 0. Reset has priority over clr, and clr has priority over wr_en.
- Write: if wr_en && wr_sel < NUM_CH && !(ZERO_CH0 && wr_sel == 0), then mem[wr_sel] <= wr_data at the edge. Otherwise no channel changes.
- Read, per port independently:
  - If rd_en is high, then at the edge rd_data <= value(rd_sel) and rd_vld <= 1.
  - If rd_en is low, rd_data holds its previous value and rd_vld <= 0.
- value(s) rules, in priority order:
  - s >= NUM_CH gives 0.
  - ZERO_CH0 && s == 0 gives 0.
  - clr asserted in the same cycle gives 0.
  - A qualifying write to s in the same cycle gives wr_data (bypass).
  - Otherwise mem[s].
- Both ports may select the same channel. Both then return the same value, and both bypass if that channel is being written.
- sel_err <= (wr_en && wr_sel >= NUM_CH) || (rd_en_a && rd_sel_a >= NUM_CH) || (rd_en_b && rd_sel_b >= NUM_CH). It can only be set when NUM_CH is not a power of two.
- An out-of-range read still returns 0 with rd_vld = 1.
- clr zeroes every channel at the edge. Read data is unaffected until the next read.

## Timing
- Write-to-storage latency: 1 edge.
- Read latency: 1 cycle, from the edge sampling rd_en/rd_sel to valid rd_data/rd_vld.
- Write followed by a read of the same channel one cycle later returns the new data from storage.
- Same-cycle write and read of the same channel returns the new data via bypass. There is no stale-read window.
- Reset, with rst_n low at an edge:
  - All outputs (rd_data_a/b, rd_vld_a/b, sel_err) go to 0 at that edge.
  - All channels go to 0.
  - Any write or read in progress in that cycle is discarded.
- Outputs are driven only from flops. There is no combinational path from inputs to outputs.
- The block is fully pipelined: a new read per port and a write are accepted every cycle, with no stalls.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with wr_en = 1, wr_sel = 3, wr_data = 20'hABCDE.
  - After release, reading ch 3 gives 0, and rd_vld_a = 0 during reset.
- Write/read sweep: write ch i = i*20'h1111 + 1 for all i, then read ch i on port A and ch NUM_CH-1-i on port B in the same cycle.
  - Each port returns the expected value with 1-cycle latency and rd_vld high for exactly the read cycles.
- Bypass: mem[5] = 20'h00001; in one cycle write ch 5 = 20'h7FFFF and read ch 5 on both ports.
  - Both rd_data_a and rd_data_b = 20'h7FFFF the next cycle.
- ZERO_CH0 = 1: write ch 0 = 20'hFFFFF.
  - Reading ch 0 gives 0. A same-cycle read of ch 0 also gives 0 with no bypass.
- NUM_CH = 20, SEL_W = 5: write sel 25 and read sel 31 on port B.
  - No channel changes, rd_data_b = 0, rd_vld_b = 1, and sel_err pulses high for 1 cycle.
- clr: fill all channels, then in one cycle assert clr, a write to ch 2, and a read of ch 2.
  - Read returns 0, ch 2 reads 0 afterwards, and all channels read 0.
  - With rd_en low in that cycle, rd_data keeps its prior value.
